alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Execute-side issue stage that drives the ALU's operand and opcode inputs (a, b, op).
- Accepts a fetched/decoded instruction with its PC and register-file read data.
- Decodes RV32I opcode/funct3/funct7 into the 4-bit ALU op, builds the immediate, and selects operands.
- Presents the result through a registered valid/ready pipeline stage with a one-entry skid buffer. Sits between register read and the ALU.

Parameters:
- XLEN, 32, datapath width of operands and PC (only 32 supported).
- PC_INC, 4, constant added to PC for JAL/JALR link value.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discard all buffered and incoming entries.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept an entry.
- in_instr  input  32  raw instruction word.
- in_pc  input  XLEN  instruction PC.
- in_rs1_data  input  XLEN  rs1 read data.
- in_rs2_data  input  XLEN  rs2 read data.
- out_valid  output  1  issued entry valid.
- out_ready  input  1  ALU/EX consumer accepts.
- out_a  output  XLEN  ALU operand a.
- out_b  output  XLEN  ALU operand b.
- out_op  output  4  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
- out_pc  output  XLEN  PC passthrough.
- out_rd  output  5  destination register.
- out_we  output  1  register writeback enable (0 for rd==0, store, branch).
- out_illegal  output  1  unsupported instruction flag (see Optional Feature).

Behaviour:
- Reset: out_valid=0, skid empty, out_a/out_b/out_pc=0, out_op=0, out_rd=0, out_we=0, out_illegal=0. in_ready=0 while rst is high, 1 on the first cycle after.
- Handshake: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready. out_* are held stable while out_valid&&!out_ready.
- Latency: 1 cycle from accepted input to out_valid when not stalled.
- Storage is two slots, main and skid. in_ready = !skid_valid, registered, with no combinational path from out_ready.
  - Accept while main is empty or draining: load main.
  - Accept while main is held (out_valid && !out_ready): load skid.
  - Main drains with skid full: skid moves to main; in_ready returns to 1 next cycle.
  - Throughput is 1 entry per cycle under continuous out_ready.
- Flush has priority over everything. Next cycle: out_valid=0, skid empty, in_ready=1. An input presented in the flush cycle is dropped. A flush coinciding with an output transfer still completes that transfer.
- Decode (opcode → op, a, b, we):
  - 0110011 R-type: funct3/funct7 → ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND; a=rs1, b=rs2.
  - 0010011 I-ALU: a=rs1, b=sext(I-imm). SLLI/SRLI/SRAI use b={27'b0,shamt}. SRAI is selected by instr[30]=1.
  - 0110111 LUI: ADD, a=0, b=U-imm. 0010111 AUIPC: ADD, a=pc, b=U-imm.
  - 0000011 load: ADD, a=rs1, b=I-imm. 0100011 store: ADD, a=rs1, b=S-imm, we=0.
  - 1100011 branch, we=0, a=rs1, b=rs2: BEQ/BNE→SUB, BLT/BGE→SLT, BLTU/BGEU→SLTU.
  - 1101111 JAL / 1100111 JALR: ADD, a=pc, b=PC_INC.
- out_we=0 whenever rd==0.
- Unsupported opcode: op=ADD, a=b=0, we=0.

Optional Feature:
- Macro ALU_ISSUE_ILLEGAL_EN.
- Defined:
  - out_illegal=1 for an unsupported opcode.
  - Also flags R-type funct7 not in {0000000, 0100000} or 0100000 with funct3 not in {000, 101}.
  - Also flags I-shift with instr[31:25] illegal. Flagged entries force we=0.
- Undefined: out_illegal tied 0; only opcode fallback applies, and funct7 is checked only on bit 30.

Decomposition:
- Package alu_pkg: alu_op_e enum (4-bit, values above), RV32I opcode localparams, issue payload struct (a, b, op, pc, rd, we, illegal).
- Sub-module alu_issue_dec: purely combinational instr/pc/rs data → payload.
- Top alu_issue holds main/skid registers and handshake.

Test Plan:
- Reset: hold rst 3 cycles → out_valid=0, in_ready=0 during reset; in_ready=1 the cycle after.
- R-type SUB 0x40208033 (sub x0,x1,x2), rs1=5, rs2=7, out_ready=1 → next cycle out_op=1, a=5, b=7, out_we=0 (rd=x0).
- SRAI 0x4030d093, rs1=0x80000000 → out_op=7, b=3, out_rd=1, out_we=1. AUIPC 0x00001117, pc=0x100 → op=0, a=0x100, b=0x1000.
- Backpressure: stream 3 entries with out_ready=0 → first in main, second in skid, in_ready=0, third held. Raise out_ready → entries emerge in order, no loss or duplication.
- Flush with main and skid full plus in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed entries never appear.
- Illegal opcode 0x0000007f: with the macro → out_illegal=1, we=0. Without it → op=0, a=b=0, we=0, out_illegal=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: ALU op encoding,
// RV32I major opcodes and the issue payload bundle.
package alu_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      alu_op_e           op;
      logic [DATA_W-1:0] pc;
      logic [4:0]        rd;
      logic              we;
      logic              illegal;
   } issue_t;

endpackage

// File: rtl/alu_issue_dec.sv
// Combinational RV32I decode: instr/pc/rs data -> issue payload.
// Ports: instr, pc, rs1_data, rs2_data in; pl (issue_t) out.
// ALU_ISSUE_ILLEGAL_EN enables funct7 and unknown-opcode flagging.
module alu_issue_dec
   import alu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int PC_INC = 4
) (
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   output issue_t          pl
);

   logic [6:0]      opc;
   logic [2:0]      f3;
   logic [4:0]      rd;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] shamt;
   logic            wr_ok;
`ifdef ALU_ISSUE_ILLEGAL_EN
   logic [6:0]      f7;
   logic            ill;
   assign f7 = instr[31:25];
`endif

   assign opc   = instr[6:0];
   assign f3    = instr[14:12];
   assign rd    = instr[11:7];
   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_u = {instr[31:12], 12'b0};
   assign shamt = {27'b0, instr[24:20]};

   always_comb begin
      pl      = '0;
      pl.op   = ALU_ADD;
      pl.pc   = pc;
      pl.rd   = rd;
      wr_ok   = 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_EN
      ill     = 1'b0;
`endif
      unique case (opc)
         OPC_OP: begin
            pl.a  = rs1_data;
            pl.b  = rs2_data;
            wr_ok = 1'b1;
            unique case (f3)
               3'b000: pl.op = instr[30] ? ALU_SUB : ALU_ADD;
               3'b001: pl.op = ALU_SLL;
               3'b010: pl.op = ALU_SLT;
               3'b011: pl.op = ALU_SLTU;
               3'b100: pl.op = ALU_XOR;
               3'b101: pl.op = instr[30] ? ALU_SRA : ALU_SRL;
               3'b110: pl.op = ALU_OR;
               3'b111: pl.op = ALU_AND;
            endcase
`ifdef ALU_ISSUE_ILLEGAL_EN
            // Only SUB and SRA use the alternate funct7.
            ill = !((f7 == 7'h00) ||
                    (f7 == 7'h20 &&
                     (f3 == 3'b000 || f3 == 3'b101)));
`endif
         end
         OPC_OP_IMM: begin
            pl.a  = rs1_data;
            pl.b  = imm_i;
            wr_ok = 1'b1;
            unique case (f3)
               3'b000: pl.op = ALU_ADD;
               3'b001: begin
                  pl.op = ALU_SLL;
                  pl.b  = shamt;
               end
               3'b010: pl.op = ALU_SLT;
               3'b011: pl.op = ALU_SLTU;
               3'b100: pl.op = ALU_XOR;
               3'b101: begin
                  pl.op = instr[30] ? ALU_SRA : ALU_SRL;
                  pl.b  = shamt;
               end
               3'b110: pl.op = ALU_OR;
               3'b111: pl.op = ALU_AND;
            endcase
`ifdef ALU_ISSUE_ILLEGAL_EN
            if (f3 == 3'b001)
               ill = (f7 != 7'h00);
            else if (f3 == 3'b101)
               ill = !(f7 == 7'h00 || f7 == 7'h20);
`endif
         end
         OPC_LUI: begin
            pl.b  = imm_u;
            wr_ok = 1'b1;
         end
         OPC_AUIPC: begin
            pl.a  = pc;
            pl.b  = imm_u;
            wr_ok = 1'b1;
         end
         OPC_LOAD: begin
            pl.a  = rs1_data;
            pl.b  = imm_i;
            wr_ok = 1'b1;
         end
         OPC_STORE: begin
            pl.a = rs1_data;
            pl.b = imm_s;
         end
         OPC_BRANCH: begin
            pl.a = rs1_data;
            pl.b = rs2_data;
            unique case (f3[2:1])
               2'b00:   pl.op = ALU_SUB;
               2'b10:   pl.op = ALU_SLT;
               2'b11:   pl.op = ALU_SLTU;
               default: pl.op = ALU_ADD;
            endcase
         end
         OPC_JAL, OPC_JALR: begin
            // Link value pc + PC_INC is produced by the ALU.
            pl.a  = pc;
            pl.b  = XLEN'(PC_INC);
            wr_ok = 1'b1;
         end
         default: begin
`ifdef ALU_ISSUE_ILLEGAL_EN
            ill = 1'b1;
`endif
         end
      endcase
`ifdef ALU_ISSUE_ILLEGAL_EN
      pl.illegal = ill;
      pl.we      = wr_ok && (rd != 5'd0) && !ill;
`else
      pl.illegal = 1'b0;
      pl.we      = wr_ok && (rd != 5'd0);
`endif
   end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decode plus a registered valid/ready slot with skid.
// Ports: clk, rst (sync high), flush, in_* handshake/data,
// out_* handshake/ALU operands. Macro: ALU_ISSUE_ILLEGAL_EN.
module alu_issue
   import alu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int PC_INC = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1_data,
   input  logic [XLEN-1:0] in_rs2_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_a,
   output logic [XLEN-1:0] out_b,
   output logic [3:0]      out_op,
   output logic [XLEN-1:0] out_pc,
   output logic [4:0]      out_rd,
   output logic            out_we,
   output logic            out_illegal
);

   issue_t dec_pl;
   issue_t main_q, main_d;
   issue_t skid_q, skid_d;
   logic   main_v_q, main_v_d;
   logic   skid_v_q, skid_v_d;
   logic   in_fire;

   alu_issue_dec #(
      .XLEN   (XLEN),
      .PC_INC (PC_INC)
   ) u_dec (
      .instr    (in_instr),
      .pc       (in_pc),
      .rs1_data (in_rs1_data),
      .rs2_data (in_rs2_data),
      .pl       (dec_pl)
   );

   // Ready depends only on skid occupancy, never on out_ready.
   assign in_ready = !rst && !skid_v_q;
   assign in_fire  = in_valid && in_ready;

   always_comb begin
      main_d   = main_q;
      main_v_d = main_v_q;
      skid_d   = skid_q;
      skid_v_d = skid_v_q;
      if (flush) begin
         main_v_d = 1'b0;
         skid_v_d = 1'b0;
      end else if (main_v_q && !out_ready) begin
         if (in_fire) begin
            skid_d   = dec_pl;
            skid_v_d = 1'b1;
         end
      end else if (skid_v_q) begin
         // in_ready is low here, so no new entry competes.
         main_d   = skid_q;
         main_v_d = 1'b1;
         skid_v_d = 1'b0;
      end else begin
         main_v_d = in_fire;
         if (in_fire)
            main_d = dec_pl;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_q   <= '0;
         skid_q   <= '0;
         main_v_q <= 1'b0;
         skid_v_q <= 1'b0;
      end else begin
         main_q   <= main_d;
         skid_q   <= skid_d;
         main_v_q <= main_v_d;
         skid_v_q <= skid_v_d;
      end
   end

   assign out_valid   = main_v_q;
   assign out_a       = main_q.a;
   assign out_b       = main_q.b;
   assign out_op      = main_q.op;
   assign out_pc      = main_q.pc;
   assign out_rd      = main_q.rd;
   assign out_we      = main_q.we;
   assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue.
// Expected payloads are hand-decoded constants queued on input transfer.
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc = '0;
   logic [31:0] in_rs1_data = '0;
   logic [31:0] in_rs2_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic [3:0]  out_op;
   logic [31:0] out_pc;
   logic [4:0]  out_rd;
   logic        out_we;
   logic        out_illegal;

   alu_issue dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_pc       (in_pc),
      .in_rs1_data (in_rs1_data),
      .in_rs2_data (in_rs2_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_a       (out_a),
      .out_b       (out_b),
      .out_op      (out_op),
      .out_pc      (out_pc),
      .out_rd      (out_rd),
      .out_we      (out_we),
      .out_illegal (out_illegal)
   );

   always #5 clk = ~clk;

`ifdef ALU_ISSUE_ILLEGAL_EN
   localparam bit ILL_EN = 1'b1;
`else
   localparam bit ILL_EN = 1'b0;
`endif

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [4:0]  rd;
      logic        we;
      logic        ill;
   } vec_t;

   vec_t tv[$];
   vec_t sb[$];
   vec_t cur;
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_out = 0;
   int   base;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic vec_t mk(logic [31:0] instr, logic [31:0] pc,
                               logic [31:0] rs1, logic [31:0] rs2,
                               logic [31:0] a, logic [31:0] b,
                               logic [3:0] op, logic [4:0] rd,
                               logic we, logic ill);
      vec_t v;
      v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
      v.a = a; v.b = b; v.op = op; v.rd = rd; v.we = we; v.ill = ill;
      return v;
   endfunction

   task automatic drive(vec_t v);
      in_valid    = 1'b1;
      in_instr    = v.instr;
      in_pc       = v.pc;
      in_rs1_data = v.rs1;
      in_rs2_data = v.rs2;
      cur         = v;
   endtask

   // Called at a negedge with inputs set; resolves the coming edge.
   task automatic cycle();
      vec_t e;
      #1;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("spurious_out", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            n_out++;
            check("out_a", out_a, e.a);
            check("out_b", out_b, e.b);
            check("out_op", 32'(out_op), 32'(e.op));
            check("out_pc", out_pc, e.pc);
            check("out_rd", 32'(out_rd), 32'(e.rd));
            check("out_we", 32'(out_we), 32'(e.we));
            check("out_illegal", 32'(out_illegal), 32'(e.ill));
         end
      end else if (out_valid && sb.size() > 0) begin
         check("hold_a", out_a, sb[0].a);
         check("hold_pc", out_pc, sb[0].pc);
      end
      if (flush)
         sb.delete();
      else if (in_valid && in_ready)
         sb.push_back(cur);
      @(negedge clk);
   endtask

   task automatic drain(int max);
      int k = 0;
      while (sb.size() > 0 && k < max) begin
         cycle();
         k++;
      end
      check("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      tv.push_back(mk(32'h40208033, 32'h0000_0010, 32'd5, 32'd7,
                      32'd5, 32'd7, 4'd1, 5'd0, 1'b0, 1'b0));
      tv.push_back(mk(32'h4030d093, 32'h0000_0014, 32'h8000_0000, 32'd0,
                      32'h8000_0000, 32'd3, 4'd7, 5'd1, 1'b1, 1'b0));
      tv.push_back(mk(32'h00001117, 32'h0000_0100, 32'd11, 32'd12,
                      32'h100, 32'h1000, 4'd0, 5'd2, 1'b1, 1'b0));
      tv.push_back(mk(32'hfff30293, 32'h0000_0104, 32'h1234, 32'd0,
                      32'h1234, 32'hffff_ffff, 4'd0, 5'd5, 1'b1, 1'b0));
      tv.push_back(mk(32'h123451b7, 32'h0000_0108, 32'h55, 32'h66,
                      32'd0, 32'h1234_5000, 4'd0, 5'd3, 1'b1, 1'b0));
      tv.push_back(mk(32'hfe20ae23, 32'h0000_010c, 32'h2000, 32'h77,
                      32'h2000, 32'hffff_fffc, 4'd0, 5'd28, 1'b0, 1'b0));
      tv.push_back(mk(32'h0020c063, 32'h0000_0110, 32'hffff_fff0, 32'd3,
                      32'hffff_fff0, 32'd3, 4'd8, 5'd0, 1'b0, 1'b0));
      tv.push_back(mk(32'h0020f063, 32'h0000_0114, 32'd9, 32'd10,
                      32'd9, 32'd10, 4'd9, 5'd0, 1'b0, 1'b0));
      tv.push_back(mk(32'h000000ef, 32'h0000_0200, 32'd1, 32'd2,
                      32'h200, 32'd4, 4'd0, 5'd1, 1'b1, 1'b0));
      tv.push_back(mk(32'h000280e7, 32'h0000_0300, 32'h4444, 32'd2,
                      32'h300, 32'd4, 4'd0, 5'd1, 1'b1, 1'b0));
      tv.push_back(mk(32'h0020b233, 32'h0000_0304, 32'd1, 32'hffff_ffff,
                      32'd1, 32'hffff_ffff, 4'd9, 5'd4, 1'b1, 1'b0));
      tv.push_back(mk(32'h0020f3b3, 32'h0000_0308, 32'hf0f0, 32'h0ff0,
                      32'hf0f0, 32'h0ff0, 4'd2, 5'd7, 1'b1, 1'b0));
      tv.push_back(mk(32'h0100a483, 32'h0000_030c, 32'h8000, 32'd0,
                      32'h8000, 32'd16, 4'd0, 5'd9, 1'b1, 1'b0));
      tv.push_back(mk(32'h0000007f, 32'h0000_0310, 32'hdead, 32'hbeef,
                      32'd0, 32'd0, 4'd0, 5'd0, 1'b0, ILL_EN));
      tv.push_back(mk(32'h40509093, 32'h0000_0314, 32'd6, 32'd0,
                      32'd6, 32'd5, 4'd5, 5'd1, !ILL_EN, ILL_EN));

      // Reset: in_ready and out_valid low while rst is held.
      @(negedge clk);
      repeat (3) begin
         check("rst_in_ready", 32'(in_ready), 32'd0);
         check("rst_out_valid", 32'(out_valid), 32'd0);
         @(negedge clk);
      end
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      check("post_rst_out_valid", 32'(out_valid), 32'd0);
      check("post_rst_a", out_a, 32'd0);
      check("post_rst_b", out_b, 32'd0);
      check("post_rst_pc", out_pc, 32'd0);
      check("post_rst_op", 32'(out_op), 32'd0);
      check("post_rst_rd", 32'(out_rd), 32'd0);
      check("post_rst_we", 32'(out_we), 32'd0);
      check("post_rst_ill", 32'(out_illegal), 32'd0);

      // Back-to-back stream: one entry per cycle.
      out_ready = 1'b1;
      foreach (tv[i]) begin
         drive(tv[i]);
         #1;
         check("stream_in_ready", 32'(in_ready), 32'd1);
         cycle();
      end
      in_valid = 1'b0;
      drain(20);
      check("stream_n_out", 32'(n_out), 32'(tv.size()));

      // Backpressure: main, skid, then third entry held off.
      base = n_out;
      out_ready = 1'b0;
      drive(tv[0]);
      cycle();
      drive(tv[1]);
      cycle();
      drive(tv[2]);
      #1;
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      cycle();
      cycle();
      out_ready = 1'b1;
      cycle();
      cycle();
      in_valid = 1'b0;
      drain(10);
      check("bp_n_out", 32'(n_out - base), 32'd3);

      // Flush with main and skid full and a new input offered.
      base = n_out;
      out_ready = 1'b0;
      drive(tv[3]);
      cycle();
      drive(tv[4]);
      cycle();
      drive(tv[5]);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      in_valid = 1'b0;
      #1;
      check("flush_out_valid", 32'(out_valid), 32'd0);
      check("flush_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      drive(tv[6]);
      cycle();
      in_valid = 1'b0;
      drain(10);
      check("flush_n_out", 32'(n_out - base), 32'd1);

      // Flush coinciding with an output transfer still delivers it.
      base = n_out;
      drive(tv[7]);
      cycle();
      in_valid = 1'b0;
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      #1;
      check("flush_xfer_valid", 32'(out_valid), 32'd0);
      check("flush_xfer_n_out", 32'(n_out - base), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
